// File: rtl/simon_round_ctrl.sv
// Simon 32/64 round datapath and sequencer driving an external key-schedule stage.
// One round per clock: done follows the start edge by 32 (encrypt) or 60 (decrypt) edges; start is ignored while busy.
module simon_round_ctrl #(
    parameter int ROUNDS    = 32,
    parameter int KEY_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        busy,
    output logic        done,
    output logic        key_load,
    output logic [5:0]  round_ctr,
    output logic        dir,
    input  logic [15:0] subkey
);

    localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);
    localparam logic [5:0] PREP_LAST = 6'(ROUNDS - KEY_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_mode_q;
    logic [31:0] r_dout;
    logic        r_done;
    logic [5:0]  r_ctr;
    logic        r_dir;
    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic        w_last;

    function automatic logic [15:0] simon_f(input logic [15:0] a);
        return ({a[14:0], a[15]} & {a[7:0], a[15:8]}) ^ {a[13:0], a[15:14]};
    endfunction

    // Decrypt runs the inverse round so the same x/y registers hold the block in both modes.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (r_mode_q) begin
            w_y_nxt = r_x ^ simon_f(r_y) ^ subkey;
            w_x_nxt = r_y;
        end else begin
            w_x_nxt = r_y ^ simon_f(r_x) ^ subkey;
            w_y_nxt = r_x;
        end
    end

    assign w_last = r_mode_q ? (r_ctr == 6'd0) : (r_ctr == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = mode ? S_PREP : S_RUN;
            S_PREP:  if (r_ctr == PREP_LAST) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == S_PREP) || (r_state == S_RUN);
        key_load = rst || (r_state == S_IDLE);
    end

    // PREP walks the schedule forward to K28..K31 so decrypt can consume keys in reverse with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_mode_q <= 1'b0;
            r_dout   <= '0;
            r_done   <= 1'b0;
            r_ctr    <= '0;
            r_dir    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ctr <= '0;
                    r_dir <= 1'b0;
                    if (start) begin
                        r_x      <= din[31:16];
                        r_y      <= din[15:0];
                        r_mode_q <= mode;
                    end
                end
                S_PREP: begin
                    if (r_ctr == PREP_LAST) begin
                        r_ctr <= LAST_IDX;
                        r_dir <= 1'b1;
                    end else begin
                        r_ctr <= r_ctr + 6'd1;
                    end
                end
                S_RUN: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    if (w_last) begin
                        r_dout <= {w_x_nxt, w_y_nxt};
                        r_done <= 1'b1;
                        r_ctr  <= '0;
                        r_dir  <= 1'b0;
                    end else if (r_mode_q) begin
                        r_ctr <= r_ctr - 6'd1;
                    end else begin
                        r_ctr <= r_ctr + 6'd1;
                    end
                end
                default: begin
                    r_ctr <= '0;
                    r_dir <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign done      = r_done;
    assign round_ctr = r_ctr;
    assign dir       = r_dir;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: emulates the key-schedule stage and checks every cycle against a transaction model.
module tb_simon_round_ctrl;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;
    localparam logic [31:0] KAT_CT  = 32'hC69B_E9BB;
    localparam logic [30:0] Z0      = 31'b1111101000100101011000011100110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        busy, done, key_load, dir;
    logic [5:0]  round_ctr;
    logic [15:0] subkey;
    logic [63:0] key = KAT_KEY;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    simon_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
        .dout(dout), .busy(busy), .done(done), .key_load(key_load),
        .round_ctr(round_ctr), .dir(dir), .subkey(subkey)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rol(input logic [15:0] a, input int n);
        return (a << n) | (a >> (16 - n));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] a, input int n);
        return (a >> n) | (a << (16 - n));
    endfunction

    function automatic logic [15:0] kword(input logic [63:0] k, input int idx);
        logic [15:0] w [0:31];
        logic [15:0] tmp;
        if (idx < 0 || idx > 31) return 16'h0;
        w[0] = k[15:0]; w[1] = k[31:16]; w[2] = k[47:32]; w[3] = k[63:48];
        for (int i = 4; i < 32; i++) begin
            tmp  = ror(w[i-1], 3) ^ w[i-3];
            tmp  = tmp ^ ror(tmp, 1);
            w[i] = ~w[i-4] ^ tmp ^ {15'b0, Z0[30 - ((i - 4) % 31)]} ^ 16'h3;
        end
        return w[idx];
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] a);
        return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
    endfunction

    function automatic logic [31:0] enc(input logic [63:0] k, input logic [31:0] b);
        logic [15:0] x, y, t;
        x = b[31:16]; y = b[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x; x = y ^ ff(x) ^ kword(k, i); y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] dec(input logic [63:0] k, input logic [31:0] b);
        logic [15:0] x, y, t;
        x = b[31:16]; y = b[15:0];
        for (int i = 31; i >= 0; i--) begin
            t = y; y = x ^ ff(y) ^ kword(k, i); x = t;
        end
        return {x, y};
    endfunction

    // Key-schedule stage: a 4-word window that reloads on key_load and slides one word per edge.
    int ks_base = 0;
    always @(posedge clk) begin
        if (key_load)  ks_base <= 0;
        else if (!dir) ks_base <= ks_base + 1;
        else           ks_base <= ks_base - 1;
    end
    always_comb subkey = kword(key, dir ? ks_base + 3 : ks_base);

    // Transaction model: t counts edges since the start-sampled edge.
    bit          m_active = 1'b0;
    bit          m_mode = 1'b0;
    bit          m_done = 1'b0;
    int          m_t = 0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_dout = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_dout = '0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == (m_mode ? 60 : 32)) begin
                    m_active = 1'b0; m_done = 1'b1; m_dout = m_exp;
                end
            end else if (start) begin
                m_active = 1'b1; m_t = 0; m_mode = mode;
                m_exp = mode ? dec(key, din) : enc(key, din);
            end
        end
    end

    function automatic int exp_rc();
        if (!m_active) return 0;
        if (!m_mode || m_t < 28) return m_t;
        return 59 - m_t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            #1;
            chk("busy", 32'(busy), 32'(m_active));
            chk("key_load", 32'(key_load), 32'(rst | !m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("dout", dout, m_dout);
            chk("round_ctr", 32'(round_ctr), 32'(exp_rc()));
            chk("dir", 32'(dir), 32'(m_active && m_mode && m_t >= 28));
        end
    end

    // Called on a negedge; returns on the negedge where done is high.
    task automatic run_op(input logic m, input logic [31:0] d, input int poke_at,
                          input logic [31:0] exp_dout, input int exp_cyc, input string nm);
        int cyc;
        start = 1'b1; mode = m; din = d;
        @(negedge clk);
        start = 1'b0; din = 32'hDEAD_BEEF;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke_at) begin
                start = 1'b1; mode = ~m; din = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(cyc), 32'(exp_cyc));
        chk({nm, "_dout"}, dout, exp_dout);
    endtask

    initial begin
        logic [31:0] pt, ct;
        chk("model_kat_enc", enc(KAT_KEY, KAT_PT), KAT_CT);
        chk("model_kat_dec", dec(KAT_KEY, KAT_CT), KAT_PT);
        chk("model_k0", 32'(kword(KAT_KEY, 0)), 32'h0100);
        chk("model_k4", 32'(kword(KAT_KEY, 4)), 32'hFFFC ^ 32'(kword(KAT_KEY, 0))
            ^ 32'(ror(16'h1918, 3) ^ 16'h0908) ^ 32'(ror(ror(16'h1918, 3) ^ 16'h0908, 1)) ^ 32'h1);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1;
        chk("rst_key_load", 32'(key_load), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ctr", 32'(round_ctr), 32'h0);

        @(negedge clk);
        run_op(1'b0, KAT_PT, -1, KAT_CT, 32, "enc_kat");
        @(negedge clk);
        run_op(1'b1, KAT_CT, -1, KAT_PT, 60, "dec_kat");
        run_op(1'b0, KAT_PT, -1, KAT_CT, 32, "b2b_enc");

        @(negedge clk);
        run_op(1'b0, KAT_PT, 10, KAT_CT, 32, "ign_run_enc");
        run_op(1'b1, KAT_CT, 5, KAT_PT, 60, "ign_prep_dec");
        run_op(1'b1, KAT_CT, 40, KAT_PT, 60, "ign_run_dec");

        @(negedge clk);
        start = 1'b1; mode = 1'b0; din = KAT_PT;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_ctr", 32'(round_ctr), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_dout", dout, 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_key_load", 32'(key_load), 32'h1);
        @(negedge clk);
        run_op(1'b0, KAT_PT, -1, KAT_CT, 32, "post_rst_enc");

        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            key = {$urandom, $urandom};
            pt  = $urandom;
            run_op(1'b0, pt, -1, enc(key, pt), 32, "rt_enc");
            ct = dout;
            run_op(1'b1, ct, -1, pt, 60, "rt_dec");
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
- Simon 32/64 round datapath and sequencer. Sits directly downstream of the Simon key-schedule stage.
- Drives that stage's load, round counter and direction inputs, and consumes the 16-bit subkey it produces.
- Accepts one 32-bit block per start command and applies 32 encryption or decryption rounds, one round per clock.
- Reports the result with a one-cycle done pulse.

Parameters:
ROUNDS, 32, number of Simon rounds (Simon 32/64).
KEY_WORDS, 4, key words held by the key schedule; decrypt prep length = ROUNDS-KEY_WORDS (28).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
mode  in  1  0 = encrypt, 1 = decrypt; sampled with start
din  in  32  input block, x = din[31:16], y = din[15:0]; sampled with start
dout  out  32  result block, held until next completion
busy  out  1  high in PREP and RUN
done  out  1  one-cycle pulse when dout updates
key_load  out  1  key-schedule reset/load; key schedule samples master key while high
round_ctr  out  6  round index to key schedule
dir  out  1  to key schedule: 0 = forward, 1 = reverse
subkey  in  16  round key from key schedule (K[i] forward, K[i] via top word in reverse)

Behaviour:
- Reset values: state IDLE, dout 0, done 0, busy 0, round_ctr 0, dir 0, internal x/y 0, mode_q 0.
- key_load = rst | (state == IDLE). The key schedule therefore reloads the master key every IDLE cycle, including the cycle start is sampled. The master key must be stable on that edge.
- The key schedule steps on every edge while key_load is low. The sequencer must never leave a gap cycle.
- Round function: f(a) = (rol1(a) & rol8(a)) ^ rol2(a), all 16-bit rotates.
  - Encrypt round: x' = y ^ f(x) ^ subkey; y' = x.
  - Decrypt round: y' = x ^ f(y) ^ subkey; x' = y.
- IDLE:
  - round_ctr = 0, dir = 0.
  - On start: latch din into x/y and mode into mode_q.
  - Next state: mode = 0 -> RUN with round_ctr = 0, dir = 0. mode = 1 -> PREP with round_ctr = 0, dir = 0.
- PREP (decrypt only):
  - dir = 0, round_ctr counts 0..ROUNDS-KEY_WORDS-1 (0..27), one per cycle. x/y untouched.
  - After the edge with round_ctr = 27 the schedule holds K28..K31. Go to RUN with dir = 1, round_ctr = ROUNDS-1 (31).
- RUN:
  - Each edge applies one round using the current subkey.
  - Encrypt: round_ctr increments 0..31.
  - Decrypt: round_ctr decrements 31..0. round_ctr always equals the index of the subkey being consumed.
  - On the edge with the final index (31 for encrypt, 0 for decrypt): write the round result to dout, set done = 1 for one cycle, go to IDLE, reset round_ctr to 0 and dir to 0.
- Latency from the start-sampled edge to done high: encrypt 32 edges, decrypt 60 edges. Throughput: a new start is accepted in the cycle done is high.
- busy = (state == PREP) | (state == RUN), decoded from state.
- start while busy: ignored; mode and din are not sampled.
- rst mid-operation: immediate return to reset values. The partial result is discarded, no done pulse, and key_load goes high.
- The round counter never exceeds 31 and never wraps; only the legal 6-bit range 0..31 is driven.

Test Plan:
- Encrypt KAT: key 0x1918_1110_0908_0100, start, mode = 0, din 0x6565_6877 -> done after 32 cycles, dout 0xC69B_E9BB, busy high exactly 32 cycles.
- Decrypt KAT: same key, mode = 1, din 0xC69B_E9BB -> busy 60 cycles (28 PREP, 32 RUN), dout 0x6565_6877; round_ctr trace 0..27 with dir = 0, then 31..0 with dir = 1.
- Back-to-back: assert start (encrypt) in the done cycle of a decrypt -> second operation completes 32 cycles later with the correct KAT output; previous dout held until then.
- start pulses while busy (random mid-RUN and mid-PREP, different din/mode) -> ignored; result and timing identical to the undisturbed KAT.
- rst asserted at RUN round 10 -> next cycle dout = 0, done = 0, busy = 0, key_load = 1; a following encrypt KAT passes.
- Random key/block round-trip (≥100 pairs): encrypt then decrypt -> original block returned; encrypt output matches the reference model.
